// File: rtl/sdram_read_agent_if.sv
// Client-side request/response bundle for sdram_read_agent.
// Handshake rule for both channels: a transfer happens on a rising iclk edge
// where valid and ready are both high; valid never waits on ready.
interface sdram_read_agent_if;
   logic         req_valid;
   logic         req_ready;
   logic [21:0]  req_addr;
   logic         rsp_valid;
   logic         rsp_ready;
   logic [127:0] rsp_data;

   // Client side: issues requests, consumes responses.
   modport master (
      output req_valid, req_addr, rsp_ready,
      input  req_ready, rsp_valid, rsp_data
   );

   // Agent side: accepts requests, produces responses.
   modport slave (
      input  req_valid, req_addr, rsp_ready,
      output req_ready, rsp_valid, rsp_data
   );
endinterface

// File: rtl/sdram_read_agent.sv
// SDRAM burst-read front-end: accepts one aligned read at a time, wins the
// shared SDRAM bus, drives the burst engine, and queues finished bursts in a
// small response FIFO. A watchdog aborts and resets a hung engine.
module sdram_read_agent #(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 64
) (
   input  logic                 iclk,
   input  logic                 ctr_reset,
   sdram_read_agent_if.slave    cli,
   output logic                 bus_req,
   input  logic                 bus_gnt,
   output logic                 rd_req,
   output logic                 rd_enb,
   output logic                 rd_ireset,
   output logic [12:0]          rd_row,
   output logic [9:0]           rd_column,
   output logic [1:0]           rd_bank,
   input  logic                 rd_fin,
   input  logic [127:0]         rd_data,
   output logic                 err,
   input  logic                 err_clr,
   output logic [1:0]           state_dbg
);

   localparam int AW = $clog2(DEPTH);
   localparam int WW = $clog2(TIMEOUT);
   localparam logic [AW:0]   FULL    = (AW + 1)'(DEPTH);
   localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_ARB, ST_ISSUE, ST_WAIT} state_t;

   state_t          state, state_next;
   logic            accept, push, pop, abort;
   logic [WW-1:0]   wd;
   logic [AW:0]     count;
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [127:0]    mem [DEPTH];

   assign state_dbg     = state;
   // Space is checked here so the single outstanding burst always has a slot.
   assign cli.req_ready = (state == ST_IDLE) && (count < FULL);
   assign cli.rsp_valid = (count != '0);
   assign cli.rsp_data  = cli.rsp_valid ? mem[rd_ptr] : '0;
   assign pop           = cli.rsp_valid && cli.rsp_ready;

   // State register.
   always_ff @(posedge iclk or posedge ctr_reset) begin
      if (ctr_reset) state <= ST_IDLE;
      else           state <= state_next;
   end

   // Next-state and per-cycle strobes; a grant drop after ARB is ignored.
   always_comb begin
      state_next = state;
      accept     = 1'b0;
      push       = 1'b0;
      abort      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (cli.req_valid && (count < FULL)) begin
               accept     = 1'b1;
               state_next = ST_ARB;
            end
         end
         ST_ARB: begin
            if (bus_gnt) state_next = ST_ISSUE;
         end
         ST_ISSUE: begin
            state_next = ST_WAIT;
         end
         ST_WAIT: begin
            if (rd_fin) begin
               push       = 1'b1;
               state_next = ST_IDLE;
            end else if (wd == WD_LAST) begin
               abort      = 1'b1;
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Registered engine/bus outputs, decoded from the state being entered.
   always_ff @(posedge iclk or posedge ctr_reset) begin
      if (ctr_reset) begin
         bus_req   <= 1'b0;
         rd_req    <= 1'b0;
         rd_enb    <= 1'b0;
         rd_ireset <= 1'b1;
         rd_row    <= '0;
         rd_column <= '0;
         rd_bank   <= '0;
      end else begin
         bus_req   <= (state_next != ST_IDLE);
         rd_req    <= (state_next == ST_ISSUE);
         rd_enb    <= (state_next == ST_ISSUE) || (state_next == ST_WAIT);
         rd_ireset <= abort;
         if (accept) begin
            rd_bank   <= cli.req_addr[21:20];
            rd_row    <= cli.req_addr[19:7];
            rd_column <= {cli.req_addr[6:0], 3'b000};
         end
      end
   end

   // Watchdog counts WAIT cycles since ISSUE; sticky error, set beats clear.
   always_ff @(posedge iclk or posedge ctr_reset) begin
      if (ctr_reset) begin
         wd  <= '0;
         err <= 1'b0;
      end else begin
         if (state == ST_ISSUE)     wd <= '0;
         else if (state == ST_WAIT) wd <= wd + 1'b1;
         if (abort)        err <= 1'b1;
         else if (err_clr) err <= 1'b0;
      end
   end

   // FIFO pointers and occupancy; simultaneous push and pop keep the count.
   always_ff @(posedge iclk or posedge ctr_reset) begin
      if (ctr_reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // FIFO storage; head is masked to zero while empty.
   always_ff @(posedge iclk) begin
      if (push) mem[wr_ptr] <= rd_data;
   end

endmodule

// File: doc/sdram_read_agent.md
# sdram_read_agent

Front-end for the SDRAM burst-read engine: accepts 128-bit-aligned read requests from a client, obtains the shared SDRAM bus from the top-level arbiter, and drives the engine's request/enable/row/column/bank inputs. It collects each finished 8×16-bit burst into a small response FIFO with a valid/ready handshake. A watchdog recovers the engine if a burst never completes.

## Interface
- DEPTH, 4, response FIFO entries (power of two, 2..16)
- TIMEOUT, 64, cycles allowed from ISSUE to rd_fin before abort (≥ 32)
- iclk  in  1  clock; engine runs on the same clock
- ctr_reset  in  1  asynchronous, active-high reset
- req_valid  in  1  client read request valid
- req_ready  out  1  agent can accept a request
- req_addr  in  22  {bank[21:20], row[19:7], col_hi[6:0]}; 128-bit word address
- rsp_valid  out  1  head of response FIFO valid
- rsp_ready  in  1  client consumes head
- rsp_data  out  128  burst data, first SDRAM word in [127:112]
- bus_req  out  1  request for SDRAM pins to arbiter
- bus_gnt  in  1  arbiter grant; held while bus_req high
- rd_req  out  1  to engine ireq
- rd_enb  out  1  to engine ienb (pin drive enable)
- rd_ireset  out  1  to engine ireset (synchronous in engine)
- rd_row  out  13  to engine irow
- rd_column  out  10  to engine icolumn = {col_hi, 3'b000}
- rd_bank  out  2  to engine ibank
- rd_fin  in  1  engine ofin, one-cycle pulse
- rd_data  in  128  engine odata, valid when rd_fin high
- err  out  1  sticky timeout flag
- err_clr  in  1  clears err

## Operation
- States: IDLE, ARB, ISSUE, WAIT.
- IDLE: req_ready = (fifo_count < DEPTH). On req_valid && req_ready, latch bank/row/col_hi into rd_bank/rd_row/rd_column; go ARB.
- ARB: bus_req = 1; on bus_gnt = 1 go ISSUE.
- ISSUE (exactly 1 cycle): bus_req = 1, rd_enb = 1, rd_req = 1; clear watchdog; go WAIT.
- WAIT: bus_req = 1, rd_enb = 1, rd_req = 0. On rd_fin = 1: push rd_data into FIFO, go IDLE. Else if watchdog = TIMEOUT-1: set err, pulse rd_ireset, no push, go IDLE.
- Only one read outstanding; space is checked at acceptance so the push at rd_fin never overflows.
- rd_row/rd_column/rd_bank stable from ARB through WAIT; hold last value in IDLE.
- rd_fin outside WAIT is ignored (no push).
- FIFO: push and pop in same cycle allowed, count unchanged; pop only when rsp_valid && rsp_ready; pointers wrap modulo DEPTH.
- err: set on timeout, cleared by err_clr; set wins if both same cycle.
- bus_gnt dropping during ISSUE/WAIT is a protocol violation; agent ignores it.

## Timing
- Reset values: state IDLE, fifo empty, bus_req 0, rd_req 0, rd_enb 0, rd_ireset 1, rd_row/rd_column/rd_bank 0, rsp_valid 0, rsp_data 0, err 0. req_ready = 1 after reset (derived from IDLE/count).
- rd_ireset: 1 during reset and first cycle after release, then 0; also 1 for exactly one cycle following a timeout abort.
- All outputs except req_ready and rsp_valid/rsp_data (FIFO head) are registered.
- Latency: accept at edge N → bus_req high cycle N+1 → with bus_gnt already high, rd_req high cycle N+2 → engine ofin ≈ 15 cycles later → rsp_valid high the cycle after rd_fin.
- req_ready low in ARB/ISSUE/WAIT; next accept possible the cycle after return to IDLE.
- ctr_reset mid-burst: immediately drops bus_req/rd_enb/rd_req, flushes FIFO, and engine is reset via rd_ireset.

## Test plan
- Single read: req_addr = {2'b01, 13'h0ABC, 7'h05}, grant immediate, engine model returns 128'h0001_..._0008 → rd_row = 0ABC, rd_column = 0x028, rd_bank = 1, one rd_req pulse, rsp_valid with that data.
- Grant delay: bus_gnt held low 10 cycles → rd_req occurs exactly 1 cycle after gnt rises; bus_req high throughout.
- Backpressure: rsp_ready = 0, issue 5 requests with DEPTH = 4 → 4 complete, req_ready low afterward; pop one → 5th accepted; data order preserved.
- Simultaneous push/pop: rd_fin in the same cycle as a pop with count = 2 → count stays 2.
- Timeout: engine never asserts rd_fin → after 64 cycles err = 1, rd_ireset pulses once, no push, req_ready = 1; err_clr → err = 0.
- Reset mid-WAIT: assert ctr_reset → all outputs at reset values, FIFO empty, rd_ireset high one cycle after release.
